seg_scan_8: RTL and testbench

Eight-digit seven-segment scan driver for the digital clock display path. It sits directly downstream of the time counter: it takes the 32-bit packed BCD word (eight nibbles, digit 0 in [3:0]) and time-multiplexes it onto one shared common-anode segment bus plus eight digit enables. It decodes 0–9, 0xA as '-' and 0xB–0xF as blank, takes a per-digit decimal-point mask, and applies an anti-ghosting blank gap between digits. The word is captured once per frame, so a counter carry never produces a torn display.

---
 rtl/seg_scan_8_if.sv | 34 +++
 rtl/seg_scan_8.sv | 110 +++++++++++
 tb/tb_seg_scan_8.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_8_if.sv
// seg_scan_8_if: display-path bundle between the time counter and the scan driver.
//   disp_en     1   1 drives digits, 0 blanks the enables (scan keeps running)
//   data_in     32  packed BCD nibbles, digit i in [4i+3:4i]
//   dp_in       8   decimal-point mask, bit i lights digit i
//   an          8   digit enables, active-low
//   seg         8   {dp,g,f,e,d,c,b,a}, active-low
//   frame_start 1   one-cycle pulse as digit 0's slot begins
// master: the side that supplies the word; slave: the scan driver.
interface seg_scan_8_if;
    logic        disp_en;
    logic [31:0] data_in;
    logic [7:0]  dp_in;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        frame_start;

    modport master (
        output disp_en,
        output data_in,
        output dp_in,
        input  an,
        input  seg,
        input  frame_start
    );

    modport slave (
        input  disp_en,
        input  data_in,
        input  dp_in,
        output an,
        output seg,
        output frame_start
    );
endinterface

// File: rtl/seg_scan_8.sv
// seg_scan_8: eight-digit common-anode seven-segment scan driver.
// Time-multiplexes a packed BCD word onto one segment bus plus eight digit enables.
// The word and dp mask are captured once per frame (on the 7->0 wrap) so a counter
// carry can never tear the display. Codes 0-9 render digits, A renders '-', B-F blank.
// Ports:
//   sys_clk  in   system clock, rising edge
//   sys_rst  in   synchronous active-high reset
//   bus      slave modport of seg_scan_8_if (disp_en, data_in, dp_in in; an, seg,
//            frame_start out, all outputs registered)
// Parameters:
//   SCAN_DIV   clock cycles per digit slot (>= BLANK_CYC+2)
//   BLANK_CYC  cycles at the start of each slot with all digits off; 0 disables the gap
module seg_scan_8 #(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    seg_scan_8_if.slave   bus
);

    localparam int unsigned PcntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PcntW-1:0] PcntMax = PcntW'(SCAN_DIV - 1);

    logic [PcntW-1:0] pcnt_q, pcnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      shadow_data_q, shadow_data_d;
    logic [7:0]       shadow_dp_q, shadow_dp_d;
    logic [7:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;
    logic             frame_start_q, frame_start_d;

    logic             tick;
    logic             wrap;
    logic             gap;
    logic [3:0]       nibble;
    logic [7:0]       glyph;

    // Active-low glyph with the dp bit parked high; dp is merged separately.
    function automatic logic [7:0] decode(input logic [3:0] code);
        logic [7:0] g;
        case (code)
            4'h0:    g = 8'hC0;
            4'h1:    g = 8'hF9;
            4'h2:    g = 8'hA4;
            4'h3:    g = 8'hB0;
            4'h4:    g = 8'h99;
            4'h5:    g = 8'h92;
            4'h6:    g = 8'h82;
            4'h7:    g = 8'hF8;
            4'h8:    g = 8'h80;
            4'h9:    g = 8'h90;
            4'hA:    g = 8'hBF;
            default: g = 8'hFF;
        endcase
        return g;
    endfunction

    always_comb begin
        tick   = (pcnt_q == PcntMax);
        wrap   = tick && (idx_q == 3'd7);
        pcnt_d = tick ? '0 : pcnt_q + 1'b1;
        idx_d  = tick ? idx_q + 3'd1 : idx_q;

        shadow_data_d = wrap ? bus.data_in : shadow_data_q;
        shadow_dp_d   = wrap ? bus.dp_in   : shadow_dp_q;

        // Outputs are computed from next-state values so a newly captured word shows on
        // digit 0 in the very cycle after the wrap edge.
        nibble = shadow_data_d[{idx_d, 2'b00} +: 4];
        glyph  = decode(nibble);
        seg_d  = {~shadow_dp_d[idx_d], glyph[6:0]};

        an_d = (gap || !bus.disp_en) ? 8'hFF : ~(8'b1 << idx_d);

        frame_start_d = wrap;
    end

    // With no gap the comparison would be against zero, so it is elaborated only when needed.
    if (BLANK_CYC == 0) begin : g_no_gap
        assign gap = 1'b0;
    end else begin : g_gap
        assign gap = (pcnt_d < PcntW'(BLANK_CYC));
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pcnt_q        <= '0;
            idx_q         <= 3'd0;
            shadow_data_q <= 32'h0;
            shadow_dp_q   <= 8'h0;
            an_q          <= 8'hFF;
            seg_q         <= 8'hFF;
            frame_start_q <= 1'b0;
        end else begin
            pcnt_q        <= pcnt_d;
            idx_q         <= idx_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.an          = an_q;
    assign bus.seg         = seg_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_8.sv
// Directed bench for seg_scan_8. Two instances share one clock:
//   u_dut_a: SCAN_DIV = 4, BLANK_CYC = 0 (scan order, frame coherence, codes, disp_en, reset)
//   u_dut_b: SCAN_DIV = 8, BLANK_CYC = 2 (anti-ghost gap)
// Outputs are sampled 1 time unit after the rising edge.
module tb_seg_scan_8;

    logic sys_clk = 1'b0;
    logic rst_a;
    logic rst_b;

    int checks = 0;
    int errors = 0;

    seg_scan_8_if bus_a ();
    seg_scan_8_if bus_b ();

    seg_scan_8 #(
        .SCAN_DIV  (4),
        .BLANK_CYC (0)
    ) u_dut_a (
        .sys_clk (sys_clk),
        .sys_rst (rst_a),
        .bus     (bus_a)
    );

    seg_scan_8 #(
        .SCAN_DIV  (8),
        .BLANK_CYC (2)
    ) u_dut_b (
        .sys_clk (sys_clk),
        .sys_rst (rst_b),
        .bus     (bus_b)
    );

    always #5 sys_clk = ~sys_clk;

    // Hand-decoded expectations, digit 0 first.
    logic [7:0] seg_f2  [8] = '{8'hBF, 8'hBF, 8'h99, 8'hB0, 8'hBF, 8'hBF, 8'hA4, 8'hF9};
    logic [7:0] seg_cod [8] = '{8'h00, 8'h90, 8'hBF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] seg_b   [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    initial begin
        logic [7:0] an_exp;
        int         fs_cnt;

        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.disp_en = 1'b1;
        bus_a.data_in = 32'h12AA34AA;
        bus_a.dp_in   = 8'h00;
        bus_b.disp_en = 1'b1;
        bus_b.data_in = 32'h76543210;
        bus_b.dp_in   = 8'h00;

        // Reset state
        tick(2);
        chk("a_rst_an",  bus_a.an,  8'hFF);
        chk("a_rst_seg", bus_a.seg, 8'hFF);
        chk("a_rst_fs",  {7'b0, bus_a.frame_start}, 8'h00);
        chk("b_rst_an",  bus_b.an,  8'hFF);
        chk("b_rst_seg", bus_b.seg, 8'hFF);

        // Frame 1 shows the zero shadow
        rst_a = 1'b0;
        tick(1);
        chk("a_f1_seg", bus_a.seg, 8'hC0);
        chk("a_f1_an",  bus_a.an,  8'hFE);

        // Frame 2: captured 12AA34AA, 4 cycles per digit
        tick(31);
        chk("a_f2_fs", {7'b0, bus_a.frame_start}, 8'h01);
        for (int d = 0; d < 8; d++) begin
            an_exp = ~(8'b1 << d);
            chk("a_f2_seg", bus_a.seg, seg_f2[d]);
            chk("a_f2_an",  bus_a.an,  an_exp);
            if (d == 0) begin
                tick(1);
                chk("a_f2_fs_drop", {7'b0, bus_a.frame_start}, 8'h00);
                tick(3);
            end else begin
                tick(4);
            end
        end

        // Frame coherence: 59 captured, then 100 arrives mid-frame
        bus_a.data_in = 32'h00000059;
        tick(32);
        chk("a_coh_fs",   {7'b0, bus_a.frame_start}, 8'h01);
        chk("a_coh_d0",   bus_a.seg, 8'h90);
        tick(4);
        chk("a_coh_d1",   bus_a.seg, 8'h92);
        tick(8);
        bus_a.data_in = 32'h00000100;
        tick(4);
        for (int d = 4; d < 8; d++) begin
            chk("a_coh_old", bus_a.seg, 8'hC0);
            chk("a_coh_fs0", {7'b0, bus_a.frame_start}, 8'h00);
            tick(4);
        end
        chk("a_new_fs", {7'b0, bus_a.frame_start}, 8'h01);
        chk("a_new_d0", bus_a.seg, 8'hC0);
        tick(4);
        chk("a_new_d1", bus_a.seg, 8'hC0);
        chk("a_new_an1", bus_a.an, 8'hFD);
        tick(4);
        chk("a_new_d2", bus_a.seg, 8'hF9);
        chk("a_new_an2", bus_a.an, 8'hFB);

        fs_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            tick(1);
            if (bus_a.frame_start === 1'b1) fs_cnt++;
        end
        chk("a_fs_per_frame", 8'(fs_cnt), 8'd1);

        // Codes B-F, '-', and decimal point on digit 0
        bus_a.data_in = 32'hFEDCBA98;
        bus_a.dp_in   = 8'h01;
        tick(24);
        for (int d = 0; d < 8; d++) begin
            chk("a_code_seg", bus_a.seg, seg_cod[d]);
            tick(4);
        end

        // disp_en low for 10 cycles during digit 1
        tick(5);
        bus_a.disp_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("a_dis_an", bus_a.an, 8'hFF);
            if (i == 2) chk("a_dis_seg_adv", bus_a.seg, 8'hBF);
        end
        bus_a.disp_en = 1'b1;
        tick(1);
        chk("a_dis_resume", bus_a.an, 8'hEF);

        // Reset mid-frame at digit 5
        tick(4);
        chk("a_d5_an", bus_a.an, 8'hDF);
        tick(1);
        rst_a = 1'b1;
        tick(1);
        chk("a_mrst_an",  bus_a.an,  8'hFF);
        chk("a_mrst_seg", bus_a.seg, 8'hFF);
        chk("a_mrst_fs",  {7'b0, bus_a.frame_start}, 8'h00);
        rst_a = 1'b0;
        tick(1);
        chk("a_post_seg0", bus_a.seg, 8'hC0);
        chk("a_post_an0",  bus_a.an,  8'hFE);
        tick(3);
        chk("a_post_seg1", bus_a.seg, 8'hC0);
        chk("a_post_an1",  bus_a.an,  8'hFD);

        // Anti-ghost gap on the second instance
        rst_b = 1'b0;
        tick(1);
        chk("b_first_an",  bus_b.an,  8'hFF);
        chk("b_first_seg", bus_b.seg, 8'hC0);
        tick(1);
        chk("b_first_on",  bus_b.an,  8'hFE);
        tick(62);
        chk("b_f2_fs", {7'b0, bus_b.frame_start}, 8'h01);
        for (int d = 0; d < 8; d++) begin
            for (int c = 0; c < 8; c++) begin
                an_exp = (c < 2) ? 8'hFF : ~(8'b1 << d);
                chk("b_gap_an",  bus_b.an,  an_exp);
                chk("b_gap_seg", bus_b.seg, seg_b[d]);
                tick(1);
            end
        end
        chk("b_f3_fs", {7'b0, bus_b.frame_start}, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
